// File: rtl/sfr_arb_pkg.sv
// Shared constants and state type for the SFR access arbiter.
package sfr_arb_pkg;

  localparam int SFR_ADDR_W    = 5;
  localparam int SFR_DATA_W    = 8;
  localparam int PTR_CTL_W     = 7;
  localparam int PROT_LO_END   = 9;
  localparam int PROT_HI_START = 28;

  typedef enum logic {
    NORMAL = 1'b0,
    STEAL  = 1'b1
  } arb_state_e;

endpackage

// File: rtl/sfr_access_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr_i, wrapping.
module rr_pick #(
  parameter int N     = 4,
  parameter int PTR_W = 2
) (
  input  logic [N-1:0]     req_i,
  input  logic [PTR_W-1:0] ptr_i,
  output logic [N-1:0]     sel_o,
  output logic [PTR_W-1:0] idx_o,
  output logic             any_o
);

  logic [N-1:0] rot;

  always_comb begin
    // rot[k] is the request of requester (ptr_i + k) mod N
    rot   = N'({req_i, req_i} >> ptr_i);
    sel_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!any_o && rot[k]) begin
        any_o = 1'b1;
        idx_o = PTR_W'((int'(ptr_i) + k) % N);
      end
    end
    if (any_o) sel_o = N'(1) << idx_o;
  end

endmodule

// File: rtl/sfr_access_arbiter.sv
// Arbitrates the SFR file port between the CPU memory stage and NUM_REQ peripherals.
// Optional write protection of pointer/mirror addresses: define SFR_ARB_PROTECT_EN.
module sfr_access_arbiter
  import sfr_arb_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int MAX_WAIT = 15,
  parameter int CNT_W    = 4
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          cpu_wr_en,
  input  logic                          cpu_rd_en,
  input  logic [SFR_ADDR_W-1:0]         cpu_wr_addr,
  input  logic [SFR_ADDR_W-1:0]         cpu_rd_addr,
  input  logic [SFR_DATA_W-1:0]         cpu_wdata,
  input  logic [PTR_CTL_W-1:0]          cpu_ptr_ctl,
  output logic                          cpu_stall,
  output logic [SFR_DATA_W-1:0]         cpu_rdata,
  input  logic [NUM_REQ-1:0]            per_req,
  input  logic [NUM_REQ-1:0]            per_we,
  input  logic [SFR_ADDR_W*NUM_REQ-1:0] per_addr,
  input  logic [SFR_DATA_W*NUM_REQ-1:0] per_wdata,
  output logic [NUM_REQ-1:0]            per_gnt,
  output logic [NUM_REQ-1:0]            per_rvalid,
  output logic [SFR_DATA_W-1:0]         per_rdata,
  output logic [NUM_REQ-1:0]            per_err,
  output logic [1:0]                    sfr_wren,
  output logic [SFR_ADDR_W-1:0]         sfr_wr_addr,
  output logic [SFR_DATA_W-1:0]         sfr_wdata,
  output logic [SFR_ADDR_W-1:0]         sfr_rd_addr,
  output logic [PTR_CTL_W-1:0]          sfr_ptr_ctl,
  input  logic [SFR_DATA_W-1:0]         sfr_rdata
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  arb_state_e              state_q, state_d;
  logic [PTR_W-1:0]        rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]        wait_cnt_q, wait_cnt_d;
  logic [NUM_REQ-1:0]      rd_owner_q, rd_owner_d;

  logic [NUM_REQ-1:0]      pick_sel;
  logic [PTR_W-1:0]        pick_idx;
  logic                    pick_any;
  logic                    cpu_active;
  logic                    grant;
  logic                    sel_we;
  logic                    sel_prot;
  logic [SFR_ADDR_W-1:0]   sel_addr;
  logic [SFR_DATA_W-1:0]   sel_wdata;

  rr_pick #(.N(NUM_REQ), .PTR_W(PTR_W)) u_rr_pick (
    .req_i (per_req),
    .ptr_i (rr_ptr_q),
    .sel_o (pick_sel),
    .idx_o (pick_idx),
    .any_o (pick_any)
  );

  assign cpu_active = cpu_wr_en | cpu_rd_en | (cpu_ptr_ctl != '0);

  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (pick_sel[k]) begin
        sel_we    = per_we[k];
        sel_addr  = per_addr[k*SFR_ADDR_W +: SFR_ADDR_W];
        sel_wdata = per_wdata[k*SFR_DATA_W +: SFR_DATA_W];
      end
    end
  end

`ifdef SFR_ARB_PROTECT_EN
  // Pointer registers and input mirrors are owned by the core; peripherals may only read them
  assign sel_prot = sel_we && ((sel_addr <= SFR_ADDR_W'(PROT_LO_END)) ||
                               (sel_addr >= SFR_ADDR_W'(PROT_HI_START)));
`else
  assign sel_prot = 1'b0;
`endif

  always_comb begin
    state_d     = NORMAL;
    rr_ptr_d    = rr_ptr_q;
    wait_cnt_d  = '0;
    rd_owner_d  = '0;
    grant       = 1'b0;
    cpu_stall   = 1'b0;
    cpu_rdata   = '0;
    per_gnt     = '0;
    per_rvalid  = '0;
    per_rdata   = '0;
    per_err     = '0;
    sfr_wren    = 2'b00;
    sfr_wr_addr = '0;
    sfr_wdata   = '0;
    sfr_rd_addr = '0;
    sfr_ptr_ctl = '0;
    if (!reset) begin
      cpu_rdata  = sfr_rdata;
      per_rvalid = rd_owner_q;
      if (rd_owner_q != '0) per_rdata = sfr_rdata;
      cpu_stall  = (state_q == STEAL);
      if ((state_q == NORMAL) && cpu_active) begin
        // The file's write overrides pointer updates, so a write never rides with a pointer command
        sfr_wren    = {cpu_rd_en, cpu_wr_en & (cpu_ptr_ctl == '0)};
        sfr_wr_addr = cpu_wr_addr;
        sfr_wdata   = cpu_wdata;
        sfr_rd_addr = cpu_rd_addr;
        sfr_ptr_ctl = cpu_ptr_ctl;
      end else if (pick_any) begin
        grant    = 1'b1;
        per_gnt  = pick_sel;
        rr_ptr_d = (pick_idx == PTR_W'(NUM_REQ - 1)) ? '0 : pick_idx + PTR_W'(1);
        if (sel_we) begin
          if (sel_prot) begin
            per_err = pick_sel;
          end else begin
            sfr_wren    = 2'b01;
            sfr_wr_addr = sel_addr;
            sfr_wdata   = sel_wdata;
          end
        end else begin
          sfr_wren    = 2'b10;
          sfr_rd_addr = sel_addr;
          rd_owner_d  = pick_sel;
        end
      end
      if (grant || (per_req == '0) || (state_q == STEAL)) begin
        wait_cnt_d = '0;
      end else if (wait_cnt_q != CNT_W'(MAX_WAIT)) begin
        wait_cnt_d = wait_cnt_q + CNT_W'(1);
      end else begin
        wait_cnt_d = wait_cnt_q;
      end
      if ((state_q == NORMAL) && !grant && (per_req != '0) && (wait_cnt_d == CNT_W'(MAX_WAIT))) begin
        state_d = STEAL;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= NORMAL;
      rr_ptr_q   <= '0;
      wait_cnt_q <= '0;
      rd_owner_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      wait_cnt_q <= wait_cnt_d;
      rd_owner_q <= rd_owner_d;
    end
  end

endmodule

// File: tb/tb_sfr_access_arbiter.sv
// Bench for sfr_access_arbiter: directed scenarios then randomized traffic against a reference model.
module tb_sfr_access_arbiter;

  localparam int NR = 4;
  localparam int MW = 15;

  logic        clock = 1'b0;
  logic        reset;
  logic        cpu_wr_en, cpu_rd_en;
  logic [4:0]  cpu_wr_addr, cpu_rd_addr;
  logic [7:0]  cpu_wdata;
  logic [6:0]  cpu_ptr_ctl;
  logic        cpu_stall;
  logic [7:0]  cpu_rdata;
  logic [NR-1:0] per_req, per_we, per_gnt, per_rvalid, per_err;
  logic [5*NR-1:0] per_addr;
  logic [8*NR-1:0] per_wdata;
  logic [7:0]  per_rdata;
  logic [1:0]  sfr_wren;
  logic [4:0]  sfr_wr_addr, sfr_rd_addr;
  logic [7:0]  sfr_wdata, sfr_rdata;
  logic [6:0]  sfr_ptr_ctl;

  logic [4:0]  r_addr [NR];
  logic [7:0]  r_wd   [NR];

  sfr_access_arbiter #(.NUM_REQ(NR), .MAX_WAIT(MW), .CNT_W(4)) dut (
    .clock(clock), .reset(reset),
    .cpu_wr_en(cpu_wr_en), .cpu_rd_en(cpu_rd_en),
    .cpu_wr_addr(cpu_wr_addr), .cpu_rd_addr(cpu_rd_addr),
    .cpu_wdata(cpu_wdata), .cpu_ptr_ctl(cpu_ptr_ctl),
    .cpu_stall(cpu_stall), .cpu_rdata(cpu_rdata),
    .per_req(per_req), .per_we(per_we), .per_addr(per_addr), .per_wdata(per_wdata),
    .per_gnt(per_gnt), .per_rvalid(per_rvalid), .per_rdata(per_rdata), .per_err(per_err),
    .sfr_wren(sfr_wren), .sfr_wr_addr(sfr_wr_addr), .sfr_wdata(sfr_wdata),
    .sfr_rd_addr(sfr_rd_addr), .sfr_ptr_ctl(sfr_ptr_ctl), .sfr_rdata(sfr_rdata)
  );

  always #5 clock = ~clock;

  always_comb begin
    for (int k = 0; k < NR; k++) begin
      per_addr[k*5 +: 5]  = r_addr[k];
      per_wdata[k*8 +: 8] = r_wd[k];
    end
  end

  int total = 0;
  int bad   = 0;

  // reference model state: round-robin start, blocked-cycle count, steal pending, read owner (-1 = none)
  int m_rr, m_wait, m_owner;
  bit m_steal;
  int n_rr, n_wait, n_owner;
  bit n_steal;

  logic          e_stall;
  logic [NR-1:0] e_gnt, e_rvalid, e_err;
  logic [1:0]    e_wren;
  logic [4:0]    e_wa, e_ra;
  logic [7:0]    e_wd, e_cpu_rd;
  logic [6:0]    e_ptr;

  logic          s_stall;
  logic [NR-1:0] s_gnt, s_rvalid, s_err;
  logic [1:0]    s_wren;
  logic [4:0]    s_wa, s_ra;
  logic [7:0]    s_wd, s_prdata;
  logic [6:0]    s_ptr;

  int gq[$];

  function automatic bit prot_addr(logic [4:0] a);
`ifdef SFR_ARB_PROTECT_EN
    return (a <= 5'd9) || (a >= 5'd28);
`else
    return 1'b0;
`endif
  endfunction

  function automatic int gq_at(int i);
    return (i < gq.size()) ? gq[i] : -1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic void model_eval();
    int  g;
    bit  busy;
    e_stall = 1'b0; e_gnt = '0; e_rvalid = '0; e_err = '0; e_wren = 2'b00;
    e_wa = '0; e_ra = '0; e_wd = '0; e_ptr = '0; e_cpu_rd = '0;
    n_rr = 0; n_wait = 0; n_owner = -1; n_steal = 1'b0;
    if (reset) return;
    e_cpu_rd = sfr_rdata;
    e_stall  = m_steal;
    if (m_owner >= 0) e_rvalid = NR'(1) << m_owner;
    busy = cpu_wr_en || cpu_rd_en || (cpu_ptr_ctl != 0);
    g = -1;
    if (busy && !m_steal) begin
      e_wren = {cpu_rd_en, cpu_wr_en};
      e_wa = cpu_wr_addr; e_wd = cpu_wdata; e_ra = cpu_rd_addr; e_ptr = cpu_ptr_ctl;
    end else begin
      for (int k = 0; k < NR; k++)
        if (g < 0 && per_req[(m_rr + k) % NR]) g = (m_rr + k) % NR;
    end
    n_rr = m_rr;
    if (g >= 0) begin
      e_gnt = NR'(1) << g;
      n_rr  = (g + 1) % NR;
      if (per_we[g]) begin
        if (prot_addr(r_addr[g])) e_err = NR'(1) << g;
        else begin e_wren = 2'b01; e_wa = r_addr[g]; e_wd = r_wd[g]; end
      end else begin
        e_wren = 2'b10; e_ra = r_addr[g]; n_owner = g;
      end
    end
    if (g >= 0 || per_req == 0 || m_steal) n_wait = 0;
    else n_wait = (m_wait < MW) ? m_wait + 1 : MW;
    n_steal = !m_steal && (g < 0) && (per_req != 0) && (n_wait == MW);
  endfunction

  task automatic step();
    @(negedge clock);
    model_eval();
    s_stall = cpu_stall; s_gnt = per_gnt; s_rvalid = per_rvalid; s_err = per_err;
    s_wren = sfr_wren; s_wa = sfr_wr_addr; s_wd = sfr_wdata; s_ra = sfr_rd_addr;
    s_ptr = sfr_ptr_ctl; s_prdata = per_rdata;
    chk("cpu_stall",  32'(cpu_stall),   32'(e_stall));
    chk("per_gnt",    32'(per_gnt),     32'(e_gnt));
    chk("per_rvalid", 32'(per_rvalid),  32'(e_rvalid));
    chk("per_err",    32'(per_err),     32'(e_err));
    chk("sfr_wren",   32'(sfr_wren),    32'(e_wren));
    chk("sfr_ptr",    32'(sfr_ptr_ctl), 32'(e_ptr));
    chk("cpu_rdata",  32'(cpu_rdata),   32'(e_cpu_rd));
    if (e_wren[0]) begin
      chk("sfr_wr_addr", 32'(sfr_wr_addr), 32'(e_wa));
      chk("sfr_wdata",   32'(sfr_wdata),   32'(e_wd));
    end
    if (e_wren[1]) chk("sfr_rd_addr", 32'(sfr_rd_addr), 32'(e_ra));
    if (e_rvalid != 0) chk("per_rdata", 32'(per_rdata), 32'(sfr_rdata));
    for (int k = 0; k < NR; k++) if (per_gnt[k]) gq.push_back(k);
    @(posedge clock);
    if (reset) begin
      m_rr = 0; m_wait = 0; m_owner = -1; m_steal = 1'b0;
    end else begin
      m_rr = n_rr; m_wait = n_wait; m_owner = n_owner; m_steal = n_steal;
    end
    #1;
    for (int k = 0; k < NR; k++) if (e_gnt[k]) per_req[k] = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    cpu_wr_en = 0; cpu_rd_en = 0; cpu_wr_addr = 0; cpu_rd_addr = 0; cpu_wdata = 0; cpu_ptr_ctl = 0;
    per_req = 0; per_we = 0; sfr_rdata = 0;
    for (int k = 0; k < NR; k++) begin r_addr[k] = 0; r_wd[k] = 0; end
    m_rr = 0; m_wait = 0; m_owner = -1; m_steal = 1'b0;
    step(); step();
    reset = 1'b0;

    // round-robin: 1010 then 1111
    gq.delete(); per_req = 4'b1010; per_we = 4'b0000;
    r_addr[1] = 5'd11; r_addr[3] = 5'd13;
    repeat (3) step();
    chk("rr1010_n", gq.size(), 2);
    chk("rr1010_0", gq_at(0), 1);
    chk("rr1010_1", gq_at(1), 3);
    gq.delete(); per_req = 4'b1111;
    for (int k = 0; k < NR; k++) r_addr[k] = 5'(16 + k);
    repeat (5) step();
    chk("rr1111_n", gq.size(), 4);
    for (int k = 0; k < NR; k++) chk("rr1111_seq", gq_at(k), k);

    // peripheral read of addr 22, data returned the next cycle
    per_req = 4'b0001; per_we = 4'b0000; r_addr[0] = 5'd22; sfr_rdata = 8'h00;
    step();
    chk("rd22_gnt", s_gnt, 4'b0001);
    chk("rd22_wren", s_wren, 2'b10);
    chk("rd22_addr", s_ra, 5'd22);
    sfr_rdata = 8'h5A;
    step();
    chk("rd22_rvalid", s_rvalid, 4'b0001);
    chk("rd22_rdata", s_prdata, 8'h5A);
    sfr_rdata = 8'h00;

    // reset held 3 cycles right after a read grant
    per_req = 4'b0001; r_addr[0] = 5'd7;
    step();
    reset = 1'b1; sfr_rdata = 8'hC3;
    repeat (3) begin
      step();
      chk("rst_rvalid", s_rvalid, 4'b0000);
      chk("rst_wren", s_wren, 2'b00);
    end
    reset = 1'b0; sfr_rdata = 8'h00;
    step();
    chk("post_rst_rvalid", s_rvalid, 4'b0000);
    gq.delete(); per_req = 4'b0011;
    repeat (3) step();
    chk("post_rst_rr", gq_at(0), 0);

    // starvation steal under a continuous pointer command
    cpu_ptr_ctl = 7'b0000001;
    per_req = 4'b0100; per_we = 4'b0100; r_addr[2] = 5'd17; r_wd[2] = 8'h3C;
    repeat (15) begin
      step();
      chk("steal_wait_gnt", s_gnt, 4'b0000);
      chk("steal_wait_stall", s_stall, 1'b0);
    end
    step();
    chk("steal_stall", s_stall, 1'b1);
    chk("steal_gnt", s_gnt, 4'b0100);
    chk("steal_wren", s_wren, 2'b01);
    chk("steal_ptr", s_ptr, 7'd0);
    step();
    chk("steal_after", s_stall, 1'b0);
    cpu_ptr_ctl = 7'd0;

    // CPU write blocks a pending peripheral
    cpu_wr_en = 1'b1; cpu_wr_addr = 5'd12; cpu_wdata = 8'hFF;
    per_req = 4'b0001; per_we = 4'b0001; r_addr[0] = 5'd20; r_wd[0] = 8'h11;
    repeat (2) begin
      step();
      chk("cpuwr_wren", s_wren, 2'b01);
      chk("cpuwr_addr", s_wa, 5'd12);
      chk("cpuwr_data", s_wd, 8'hFF);
      chk("cpuwr_gnt", s_gnt, 4'b0000);
    end
    cpu_wr_en = 1'b0;
    step();
    chk("cpuidle_gnt", s_gnt, 4'b0001);

`ifdef SFR_ARB_PROTECT_EN
    per_req = 4'b0010; per_we = 4'b0010; r_addr[1] = 5'd3; r_wd[1] = 8'h77;
    step();
    chk("prot_gnt", s_gnt, 4'b0010);
    chk("prot_err", s_err, 4'b0010);
    chk("prot_wren", s_wren, 2'b00);
    per_req = 4'b0010; r_addr[1] = 5'd24;
    step();
    chk("open_wren", s_wren, 2'b01);
    chk("open_err", s_err, 4'b0000);
`endif

    // randomized traffic: a lightly loaded CPU phase, then a heavily loaded one to provoke steals
    for (int c = 0; c < 600; c++) begin
      int idle_mod;
      idle_mod = (c < 300) ? 3 : 25;
      if ($urandom_range(0, idle_mod - 1) == 0) begin
        cpu_rd_en = 0; cpu_wr_en = 0; cpu_ptr_ctl = 0;
      end else begin
        cpu_rd_en   = 1'($urandom_range(0, 1));
        cpu_ptr_ctl = ($urandom_range(0, 3) == 0) ? 7'(1 << $urandom_range(0, 6)) : 7'd0;
        cpu_wr_en   = (cpu_ptr_ctl == 0) ? 1'($urandom_range(0, 1)) : 1'b0;
        if (!cpu_rd_en && !cpu_wr_en && cpu_ptr_ctl == 0) cpu_rd_en = 1'b1;
      end
      cpu_wr_addr = 5'($urandom); cpu_rd_addr = 5'($urandom); cpu_wdata = 8'($urandom);
      sfr_rdata = 8'($urandom);
      for (int k = 0; k < NR; k++) begin
        if (!per_req[k] && $urandom_range(0, 2) == 0) begin
          per_req[k] = 1'b1; per_we[k] = 1'($urandom_range(0, 1));
          r_addr[k] = 5'($urandom); r_wd[k] = 8'($urandom);
        end else if (per_req[k] && $urandom_range(0, 40) == 0) begin
          per_req[k] = 1'b0;
        end
      end
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
